// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - op encodings, FSM states and cycle count for mul_unit
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL   = 2'b00;
  localparam logic [1:0] MUL_OP_UMULL = 2'b01;
  localparam logic [1:0] MUL_OP_SMULL = 2'b10;

  localparam int MUL_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mul_state_t;

endpackage

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative radix-2 32x32 multiplier with 32/64-bit accumulate
module mul_unit
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        acc_en,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] acc_lo,
  input  logic [31:0] acc_hi,
  input  logic [3:0]  dest_lo,
  input  logic [3:0]  dest_hi,
  output logic        busy,
  output logic        done,
  output logic [31:0] res_lo,
  output logic [31:0] res_hi,
  output logic [3:0]  wa_lo,
  output logic [3:0]  wa_hi,
  output logic        long_res,
  output logic        flag_n,
  output logic        flag_z
);

  mul_state_t  state;
  logic [63:0] prod;
  logic [31:0] mcand;
  logic [31:0] mplr;
  logic [4:0]  cnt;
  logic        neg;
  logic        is_mul;
  logic        acc_en_r;
  logic [63:0] acc_r;

  logic        is_smull;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg_in;
  logic [32:0] calc_sum;
  logic [63:0] signed_prod;
  logic [63:0] long_sum;
  logic [31:0] short_sum;
  logic [31:0] fix_lo;
  logic [31:0] fix_hi;
  logic        fix_n;
  logic        fix_z;

  always_comb begin
    is_smull = (op == MUL_OP_SMULL);
    mag_a    = (is_smull && src_a[31]) ? (~src_a + 32'd1) : src_a;
    mag_b    = (is_smull && src_b[31]) ? (~src_b + 32'd1) : src_b;
    neg_in   = is_smull && (src_a[31] ^ src_b[31]);
  end

  // Product shifts right each step, so the multiplicand is always added at bit 32.
  assign calc_sum = {1'b0, prod[63:32]} + {1'b0, (mplr[0] ? mcand : 32'd0)};

  always_comb begin
    signed_prod = neg ? (~prod + 64'd1) : prod;
    long_sum    = signed_prod + (acc_en_r ? acc_r : 64'd0);
    short_sum   = signed_prod[31:0] + (acc_en_r ? acc_r[31:0] : 32'd0);
    if (is_mul) begin
      fix_lo = short_sum;
      fix_hi = 32'd0;
      fix_n  = short_sum[31];
      fix_z  = (short_sum == 32'd0);
    end else begin
      fix_lo = long_sum[31:0];
      fix_hi = long_sum[63:32];
      fix_n  = long_sum[63];
      fix_z  = (long_sum == 64'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      prod     <= 64'd0;
      mcand    <= 32'd0;
      mplr     <= 32'd0;
      cnt      <= 5'd0;
      neg      <= 1'b0;
      is_mul   <= 1'b0;
      acc_en_r <= 1'b0;
      acc_r    <= 64'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_lo   <= 32'd0;
      res_hi   <= 32'd0;
      wa_lo    <= 4'd0;
      wa_hi    <= 4'd0;
      long_res <= 1'b0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand    <= mag_a;
            mplr     <= mag_b;
            neg      <= neg_in;
            prod     <= 64'd0;
            cnt      <= 5'(MUL_CYCLES - 1);
            acc_r    <= {acc_hi, acc_lo};
            acc_en_r <= acc_en;
            is_mul   <= (op == MUL_OP_MUL);
            long_res <= (op != MUL_OP_MUL);
            wa_lo    <= dest_lo;
            wa_hi    <= dest_hi;
            busy     <= 1'b1;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          prod <= {calc_sum, prod[31:1]};
          mplr <= mplr >> 1;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0)
            state <= ST_FIX;
        end
        ST_FIX: begin
          res_lo <= fix_lo;
          res_hi <= fix_hi;
          flag_n <= fix_n;
          flag_z <= fix_z;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
